// File: rtl/mem_resp_pkg.sv
// Shared widths, FSM state type and helpers for the memory block responder.
// Optional statistics counters are enabled by defining MEM_RESP_STATS_EN.
package mem_resp_pkg;

   localparam int BLOCK_W  = 128;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 4;
   localparam int CNT_W    = 8;
   localparam int STAT_W   = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } mem_resp_state_t;

   // Saturating increment for the transaction counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/mem_block_ram.sv
// 2**DEPTH_LOG2 x 128-bit block store: one synchronous write port and a
// registered read port, shaped for block-RAM inference.
module mem_block_ram
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [BLOCK_W-1:0]    wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [BLOCK_W-1:0]    rdata_o
);

   logic [BLOCK_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [BLOCK_W-1:0] rdata_q;

   // Contents are deliberately not reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory stand-in for the cache's 128-bit block interface: answers block
// reads/writes after LATENCY cycles. Define MEM_RESP_STATS_EN for counters.
module mem_block_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic [ADDR_W-1:0]    i_mem_addr,
   input  logic [BLOCK_W-1:0]   i_mem_writedata,
   output logic [BLOCK_W-1:0]   o_mem_data,
   output logic                 o_mem_r_ready,
   output logic                 o_mem_w_ready,
`ifdef MEM_RESP_STATS_EN
   output logic [STAT_W-1:0]    o_rd_count,
   output logic [STAT_W-1:0]    o_wr_count,
`endif
   output mem_resp_state_t      o_dbg_state
);

   // Handshake: a request is a level held by the requester until its ready
   // pulse; ready is high for exactly one cycle, and dropping the request
   // before the latency expires cancels it without any pulse or RAM write.

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   mem_resp_state_t        state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BLOCK_W-1:0]     data_q, data_d;
   logic                   r_ready_q, r_ready_d;
   logic                   w_ready_q, w_ready_d;
   logic                   ram_we;
   logic [DEPTH_LOG2-1:0]  blk_idx;
   logic [BLOCK_W-1:0]     ram_rdata;

   // Upper address bits are dropped, so addresses alias modulo the depth.
   assign blk_idx = i_mem_addr[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      r_ready_d = 1'b0;
      w_ready_d = 1'b0;
      ram_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_mem_write) begin
               state_d = WR_WAIT;
               cnt_d   = CNT_LOAD;
            end else if (i_mem_read) begin
               state_d = RD_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         RD_WAIT: begin
            if (!i_mem_read) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = RESP;
               data_d    = ram_rdata;
               r_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WR_WAIT: begin
            if (!i_mem_write) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = RESP;
               ram_we    = 1'b1;
               w_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         r_ready_q <= 1'b0;
         w_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         r_ready_q <= r_ready_d;
         w_ready_q <= w_ready_d;
      end
   end

   // Read port tracks the live address; it has been stable since acceptance,
   // so the registered read already holds the addressed block at commit.
   mem_block_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we && !reset),
      .waddr_i (blk_idx),
      .wdata_i (i_mem_writedata),
      .raddr_i (blk_idx),
      .rdata_o (ram_rdata)
   );

   assign o_mem_data    = data_q;
   assign o_mem_r_ready = r_ready_q;
   assign o_mem_w_ready = w_ready_q;
   assign o_dbg_state   = state_q;

`ifdef MEM_RESP_STATS_EN
   logic [STAT_W-1:0] rd_count_q, wr_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (r_ready_d) begin
            rd_count_q <= sat_inc(rd_count_q);
         end
         if (w_ready_d) begin
            wr_count_q <= sat_inc(wr_count_q);
         end
      end
   end

   assign o_rd_count = rd_count_q;
   assign o_wr_count = wr_count_q;
`endif

`ifndef SYNTHESIS
   a_addr_stable: assert property (@(posedge clk) disable iff (reset)
      ((state_q == RD_WAIT && i_mem_read) || (state_q == WR_WAIT && i_mem_write))
      |-> $stable(i_mem_addr));
   a_wdata_stable: assert property (@(posedge clk) disable iff (reset)
      (state_q == WR_WAIT && i_mem_write) |-> $stable(i_mem_writedata));
   a_ready_excl: assert property (@(posedge clk) !(o_mem_r_ready && o_mem_w_ready));
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: two instances (LATENCY 4 and 1)
// checked every cycle against a transaction-level timing and memory model.
module tb_mem_block_responder;
   import mem_resp_pkg::*;

   localparam int DL2  = 10;
   localparam int LAT0 = 4;
   localparam int LAT1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               rd_i    [2];
   logic               wr_i    [2];
   logic [31:0]        addr_i  [2];
   logic [127:0]       wdata_i [2];
   logic [127:0]       data_o  [2];
   logic               rr_o    [2];
   logic               wr_o    [2];
   mem_resp_state_t    dbg_o   [2];
`ifdef MEM_RESP_STATS_EN
   logic [31:0]        rcnt_o  [2];
   logic [31:0]        wcnt_o  [2];
`endif

   mem_block_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT0)) dut0 (
      .clk(clk), .reset(reset),
      .i_mem_read(rd_i[0]), .i_mem_write(wr_i[0]),
      .i_mem_addr(addr_i[0]), .i_mem_writedata(wdata_i[0]),
      .o_mem_data(data_o[0]), .o_mem_r_ready(rr_o[0]), .o_mem_w_ready(wr_o[0]),
`ifdef MEM_RESP_STATS_EN
      .o_rd_count(rcnt_o[0]), .o_wr_count(wcnt_o[0]),
`endif
      .o_dbg_state(dbg_o[0])
   );

   mem_block_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(reset),
      .i_mem_read(rd_i[1]), .i_mem_write(wr_i[1]),
      .i_mem_addr(addr_i[1]), .i_mem_writedata(wdata_i[1]),
      .o_mem_data(data_o[1]), .o_mem_r_ready(rr_o[1]), .o_mem_w_ready(wr_o[1]),
`ifdef MEM_RESP_STATS_EN
      .o_rd_count(rcnt_o[1]), .o_wr_count(wcnt_o[1]),
`endif
      .o_dbg_state(dbg_o[1])
   );

   // Model: each transaction becomes one expected pulse at a known cycle.
   typedef struct {
      int           id;
      int           cyc;
      bit           wr;
      logic [127:0] data;
   } ev_t;

   ev_t          exp_q[$];
   logic [127:0] mem_m[int];
   logic [127:0] exp_data [2];
   int           free_e   [2];
   int           exp_rc   [2];
   int           exp_wc   [2];
   int           cyc   = 0;
   bit           armed = 0;
   int           n_cmp  = 0;
   int           n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         armed = 1;
         exp_q.delete();
         for (int id = 0; id < 2; id++) begin
            exp_data[id] = '0;
            exp_rc[id]   = 0;
            exp_wc[id]   = 0;
            free_e[id]   = cyc + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int id = 0; id < 2; id++) begin
            bit er, ew;
            er = 0;
            ew = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
               if (exp_q[k].id == id && exp_q[k].cyc == cyc) begin
                  if (exp_q[k].wr) begin
                     ew = 1;
                     exp_wc[id]++;
                  end else begin
                     er = 1;
                     exp_data[id] = exp_q[k].data;
                     exp_rc[id]++;
                  end
                  exp_q.delete(k);
                  break;
               end
            end
            check($sformatf("r_ready[%0d]", id), 128'(rr_o[id]), 128'(er));
            check($sformatf("w_ready[%0d]", id), 128'(wr_o[id]), 128'(ew));
            check($sformatf("data[%0d]", id), data_o[id], exp_data[id]);
`ifdef MEM_RESP_STATS_EN
            check($sformatf("rd_count[%0d]", id), 128'(rcnt_o[id]), 128'(exp_rc[id]));
            check($sformatf("wr_count[%0d]", id), 128'(wcnt_o[id]), 128'(exp_wc[id]));
`endif
         end
      end
   end

   function automatic int mkey(input int id, input logic [31:0] addr);
      logic [DL2-1:0] idx;
      idx = addr[DL2+3:4];
      return id * 65536 + int'(idx);
   endfunction

   // Full transaction; returns at the negedge of the expected pulse cycle.
   task automatic xact(input int id, input bit is_wr, input bit both,
                       input logic [31:0] addr, input logic [127:0] data);
      int raise, e0, commit, lat;
      lat    = (id == 0) ? LAT0 : LAT1;
      raise  = cyc + 1;
      e0     = (raise > free_e[id]) ? raise : free_e[id];
      commit = e0 + lat;
      free_e[id] = commit + 2;
      addr_i[id]  = addr;
      wdata_i[id] = data;
      wr_i[id]    = is_wr | both;
      rd_i[id]    = !is_wr | both;
      if (is_wr | both) begin
         mem_m[mkey(id, addr)] = data;
         exp_q.push_back('{id, commit, 1'b1, data});
      end else begin
         exp_q.push_back('{id, commit, 1'b0, mem_m[mkey(id, addr)]});
      end
      while (cyc < commit) @(negedge clk);
      rd_i[id] = 1'b0;
      wr_i[id] = 1'b0;
   endtask

   // Read held for 'hold' accepted edges, then withdrawn.
   task automatic abort_rd(input int id, input logic [31:0] addr, input int hold);
      int raise, e0;
      raise = cyc + 1;
      e0    = (raise > free_e[id]) ? raise : free_e[id];
      addr_i[id] = addr;
      rd_i[id]   = 1'b1;
      while (cyc < e0 + hold - 1) @(negedge clk);
      rd_i[id]   = 1'b0;
      free_e[id] = e0 + hold + 1;
   endtask

   // Write interrupted by reset one edge after acceptance.
   task automatic reset_mid_write(input int id, input logic [31:0] addr, input logic [127:0] data);
      int raise, e0;
      raise = cyc + 1;
      e0    = (raise > free_e[id]) ? raise : free_e[id];
      addr_i[id]  = addr;
      wdata_i[id] = data;
      wr_i[id]    = 1'b1;
      while (cyc < e0 + 1) @(negedge clk);
      reset    = 1'b1;
      wr_i[id] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("rst_data", data_o[id], 128'h0);
      check("rst_rready", 128'(rr_o[id]), 128'h0);
      check("rst_wready", 128'(wr_o[id]), 128'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   localparam logic [127:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
   localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] DB = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
   localparam logic [127:0] DC = 128'hCCCC_0102_0304_0506_0708_090A_0B0C_0D0E;
   localparam logic [127:0] DD = 128'hDDDD_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
   localparam logic [127:0] DE = 128'hEEEE_1234_5678_9ABC_DEF0_1357_9BDF_2468;
   localparam logic [127:0] X1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
   localparam logic [127:0] X2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

   initial begin
      reset = 1'b1;
      for (int id = 0; id < 2; id++) begin
         rd_i[id]    = 1'b0;
         wr_i[id]    = 1'b0;
         addr_i[id]  = '0;
         wdata_i[id] = '0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Write then read, same block via different byte offsets.
      xact(0, 1, 0, 32'h0000_0120, D1);
      xact(0, 0, 0, 32'h0000_012C, '0);
      check("wr_rd_data", data_o[0], D1);
      check("wr_rd_rready", 128'(rr_o[0]), 128'h1);

      // Write-back then fetch from an aliasing address.
      xact(0, 1, 0, 32'h0000_0100, DA);
      xact(0, 0, 0, 32'h0000_4100, '0);
      check("alias_data", data_o[0], DA);

      // Simultaneous read and write: write served alone.
      xact(0, 1, 1, 32'h0000_0040, DB);
      idle(4);
      xact(0, 0, 0, 32'h0000_0040, '0);
      check("simul_ram4", data_o[0], DB);

      // Aborted read, then a normal write.
      abort_rd(0, 32'h0000_0120, 2);
      idle(8);
      xact(0, 1, 0, 32'h0000_0080, DC);
      xact(0, 0, 0, 32'h0000_0080, '0);
      check("abort_then_wr", data_o[0], DC);

      // Reset during a write leaves the old block intact.
      xact(0, 1, 0, 32'h0000_0200, DE);
      reset_mid_write(0, 32'h0000_0200, DD);
      idle(2);
      xact(0, 0, 0, 32'h0000_0200, '0);
      check("rst_old_data", data_o[0], DE);

      // LATENCY=1 back-to-back: 2 writes, 3 reads.
      xact(1, 1, 0, 32'h0000_0010, X1);
      xact(1, 1, 0, 32'h0000_0020, X2);
      xact(1, 0, 0, 32'h0000_0010, '0);
      xact(1, 0, 0, 32'h0000_0020, '0);
      xact(1, 0, 0, 32'h0000_0010, '0);
      check("lat1_last_data", data_o[1], X1);
`ifdef MEM_RESP_STATS_EN
      check("stats_rd", 128'(rcnt_o[1]), 128'd3);
      check("stats_wr", 128'(wcnt_o[1]), 128'd2);
`endif

      idle(4);
      check("pending_events", 128'(exp_q.size()), 128'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
